// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared definitions for the hazard control unit and the EX-stage operand muxes.
//   hz_state_e : controller state encoding (RUN / STALL / FREEZE)
//   FWD_*      : forwarding-select encodings driven on o_fwd_a / o_fwd_b
//   fwd_sel    : forwarding priority function (EX_MEM match beats MEM_WB match)
package hazard_ctrl_unit_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_STALL  = 2'd1,
      ST_FREEZE = 2'd2
   } hz_state_e;

   localparam logic [1:0] FWD_REG   = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam logic [1:0] FWD_MEMWB = 2'b01;

   // r0 is hard-wired zero, so a write to it never forwards.
   function automatic logic [1:0] fwd_sel(input logic       exm_we,
                                          input logic [4:0] exm_rd,
                                          input logic       mwb_we,
                                          input logic [4:0] mwb_rd,
                                          input logic [4:0] src);
      logic [1:0] sel;
      sel = FWD_REG;
      if (exm_we && (exm_rd != 5'd0) && (exm_rd == src))
         sel = FWD_EXMEM;
      else if (mwb_we && (mwb_rd != 5'd0) && (mwb_rd == src))
         sel = FWD_MEMWB;
      return sel;
   endfunction

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating up-counter used for the lost-cycle performance counters.
//   i_clk / i_rst_n : clock, asynchronous active-low reset
//   i_inc           : count this cycle (held at all-ones once reached)
//   i_clr           : synchronous clear, wins over i_inc
//   o_cnt           : current count
module hazard_sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic [CNT_W-1:0] o_cnt
);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         o_cnt <= '0;
      else if (i_clr)
         o_cnt <= '0;
      else if (i_inc && (o_cnt != '1))
         o_cnt <= o_cnt + CNT_W'(1);
   end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard control unit for a 5-stage pipeline (IF_ID / ID_EX / EX_MEM / MEM_WB).
// Detects load-use, taken-branch and data-memory-wait hazards; drives per-stage
// write-enables and flushes, PC hold/redirect and EX-stage forwarding selects;
// counts lost cycles per cause in saturating counters.
//   Inputs : i_clk, i_rst_n (async, active-low), pipeline register fields
//            (source/destination regs, mem_read, reg_write), i_br_taken,
//            i_dmem_busy, i_cnt_clr
//   Outputs: o_pc_write, o_pc_src, o_*_write / o_*_flush per stage,
//            o_fwd_a / o_fwd_b, o_stall_cnt / o_flush_cnt / o_freeze_cnt
module hazard_ctrl_unit
   import hazard_ctrl_unit_pkg::*;
#(
   parameter int unsigned LD_STALL_CYC = 1,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [4:0]       i_if_id_rs,
   input  logic [4:0]       i_if_id_rt,
   input  logic [4:0]       i_id_ex_rs,
   input  logic [4:0]       i_id_ex_rt,
   input  logic             i_id_ex_mem_read,
   input  logic [4:0]       i_ex_mem_rd,
   input  logic             i_ex_mem_reg_write,
   input  logic [4:0]       i_mem_wb_rd,
   input  logic             i_mem_wb_reg_write,
   input  logic             i_br_taken,
   input  logic             i_dmem_busy,
   input  logic             i_cnt_clr,
   output logic             o_pc_write,
   output logic             o_pc_src,
   output logic             o_if_id_write,
   output logic             o_if_id_flush,
   output logic             o_id_ex_write,
   output logic             o_id_ex_flush,
   output logic             o_ex_mem_write,
   output logic             o_ex_mem_flush,
   output logic             o_mem_wb_write,
   output logic [1:0]       o_fwd_a,
   output logic [1:0]       o_fwd_b,
   output logic [CNT_W-1:0] o_stall_cnt,
   output logic [CNT_W-1:0] o_flush_cnt,
   output logic [CNT_W-1:0] o_freeze_cnt
);

   localparam logic [2:0] LD_RELOAD = 3'(LD_STALL_CYC - 1);

   hz_state_e  state, state_nxt;
   logic [2:0] cnt, cnt_nxt;
   logic       load_use;
   logic       stall_ev, flush_ev, freeze_ev;

   assign o_fwd_a = fwd_sel(i_ex_mem_reg_write, i_ex_mem_rd,
                            i_mem_wb_reg_write, i_mem_wb_rd, i_id_ex_rs);
   assign o_fwd_b = fwd_sel(i_ex_mem_reg_write, i_ex_mem_rd,
                            i_mem_wb_reg_write, i_mem_wb_rd, i_id_ex_rt);

   assign load_use = i_id_ex_mem_read && (i_id_ex_rt != 5'd0) &&
                     ((i_id_ex_rt == i_if_id_rs) || (i_id_ex_rt == i_if_id_rt));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= ST_RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // FREEZE shares RUN's decision tree: while busy the freeze branch wins
   // (which also masks i_br_taken), and the first non-busy cycle falls
   // through to the ordinary RUN rules.
   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      o_pc_write     = 1'b1;
      o_pc_src       = 1'b0;
      o_if_id_write  = 1'b1;
      o_if_id_flush  = 1'b0;
      o_id_ex_write  = 1'b1;
      o_id_ex_flush  = 1'b0;
      o_ex_mem_write = 1'b1;
      o_ex_mem_flush = 1'b0;
      o_mem_wb_write = 1'b1;
      stall_ev       = 1'b0;
      flush_ev       = 1'b0;
      freeze_ev      = 1'b0;

      if (i_dmem_busy) begin
         o_pc_write     = 1'b0;
         o_if_id_write  = 1'b0;
         o_id_ex_write  = 1'b0;
         o_ex_mem_write = 1'b0;
         o_mem_wb_write = 1'b0;
         freeze_ev      = 1'b1;
         state_nxt      = ST_FREEZE;
         cnt_nxt        = '0;
      end else if (i_br_taken) begin
         o_pc_src       = 1'b1;
         o_if_id_flush  = 1'b1;
         o_id_ex_flush  = 1'b1;
         o_ex_mem_flush = 1'b1;
         flush_ev       = 1'b1;
         state_nxt      = ST_RUN;
         cnt_nxt        = '0;
      end else if (state == ST_STALL) begin
         o_pc_write    = 1'b0;
         o_if_id_write = 1'b0;
         o_id_ex_flush = 1'b1;
         stall_ev      = 1'b1;
         if (cnt <= 3'd1) begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
         end else begin
            cnt_nxt   = cnt - 3'd1;
         end
      end else if (load_use) begin
         o_pc_write    = 1'b0;
         o_if_id_write = 1'b0;
         o_id_ex_flush = 1'b1;
         stall_ev      = 1'b1;
         if (LD_STALL_CYC > 1) begin
            state_nxt = ST_STALL;
            cnt_nxt   = LD_RELOAD;
         end else begin
            state_nxt = ST_RUN;
         end
      end else begin
         state_nxt = ST_RUN;
      end
   end

   hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_inc   (stall_ev),
      .i_clr   (i_cnt_clr),
      .o_cnt   (o_stall_cnt)
   );

   hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_inc   (flush_ev),
      .i_clr   (i_cnt_clr),
      .o_cnt   (o_flush_cnt)
   );

   hazard_sat_counter #(.CNT_W(CNT_W)) u_freeze_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_inc   (freeze_ev),
      .i_clr   (i_cnt_clr),
      .o_cnt   (o_freeze_cnt)
   );

endmodule
